// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizes and reset value for the register file.
// Used by reg_file and reg_file_rdport.
package reg_file_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] REG_RESET_VAL = 8'h00;
endpackage

// File: rtl/reg_file_rdport.sv
// reg_file_rdport: registered read port with stall hold.
// Build option REGFILE_BYPASS_EN forwards same-edge write data.
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int DW = reg_file_pkg::DATA_W,
    parameter int AW = reg_file_pkg::ADDR_W,
    parameter int NR = reg_file_pkg::NUM_REGS
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  STALL,
    input  logic [AW-1:0]         RADDR,
    input  logic [NR-1:0][DW-1:0] REGS,
    input  logic                  WRITE,
    input  logic [AW-1:0]         WADDR,
    input  logic [DW-1:0]         WDATA,
    output logic [DW-1:0]         RDATA
);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          hit;
    logic [DW-1:0] rd_next;

    // Compare is kept in both builds; BYPASS folds it away when off.
    assign hit     = BYPASS && WRITE && (WADDR == RADDR);
    assign rd_next = hit ? WDATA : REGS[RADDR];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RDATA <= DW'(REG_RESET_VAL);
        end else if (!STALL) begin
            RDATA <= rd_next;
        end
    end
endmodule

// File: rtl/reg_file.sv
// reg_file: 8x8 register file, one write port, two registered reads.
// Optional write-to-read forwarding via REGFILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = reg_file_pkg::DATA_W,
    parameter int ADDR_W   = reg_file_pkg::ADDR_W,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    input  logic              STALL,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(REG_RESET_VAL);
            end
        end else if (WRITE) begin
            regs[INADDRESS] <= IN;
        end
    end

    reg_file_rdport #(
        .DW (DATA_W),
        .AW (ADDR_W),
        .NR (NUM_REGS)
    ) u_rd1 (
        .CLK   (CLK),
        .RESET (RESET),
        .STALL (STALL),
        .RADDR (OUT1ADDRESS),
        .REGS  (regs),
        .WRITE (WRITE),
        .WADDR (INADDRESS),
        .WDATA (IN),
        .RDATA (REGOUT1)
    );

    reg_file_rdport #(
        .DW (DATA_W),
        .AW (ADDR_W),
        .NR (NUM_REGS)
    ) u_rd2 (
        .CLK   (CLK),
        .RESET (RESET),
        .STALL (STALL),
        .RADDR (OUT2ADDRESS),
        .REGS  (regs),
        .WRITE (WRITE),
        .WADDR (INADDRESS),
        .WDATA (IN),
        .RDATA (REGOUT2)
    );
endmodule
